// File: rtl/dp_ram_obi_banked.sv
// Dual-port, word-interleaved banked SRAM with two OBI slave ports.
// Per-bank conflicts are resolved by a global round-robin priority bit; responses follow after RD_LATENCY cycles.
module dp_ram_obi_banked #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    a_req_i,
    output logic                    a_gnt_o,
    input  logic [31:0]             a_addr_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic                    a_rvalid_o,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    output logic                    a_err_o,
    input  logic                    b_req_i,
    output logic                    b_gnt_o,
    input  logic [31:0]             b_addr_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic                    b_rvalid_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    output logic                    b_err_o
);

    localparam int NBE       = DATA_WIDTH / 8;
    localparam int OFF       = $clog2(NBE);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BW        = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int WA_W      = ADDR_WIDTH - OFF;
    localparam int ROW_W     = WA_W - BANK_BITS;
    localparam int DEPTH     = 1 << ROW_W;

    if (!(NUM_BANKS == 1 || NUM_BANKS == 2 || NUM_BANKS == 4 || NUM_BANKS == 8)) begin : g_bad_banks
        $error("NUM_BANKS must be a power of two in 1..8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("RD_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("DATA_WIDTH must be 32 or 64");
    end

    logic                  req   [2];
    logic [31:0]           addr  [2];
    logic                  we    [2];
    logic [NBE-1:0]        be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    logic                  oor   [2];
    logic                  inr   [2];
    logic                  gnt   [2];
    logic                  acc   [2];
    logic [WA_W-1:0]       word  [2];
    logic [BW-1:0]         bank  [2];
    logic [ROW_W-1:0]      row   [2];

    logic                  prio;
    logic                  conflict;
    logic [DATA_WIDTH-1:0] rd_word [NUM_BANKS];
    logic                  unused_offset_bits;

    assign req[0]   = a_req_i;
    assign req[1]   = b_req_i;
    assign addr[0]  = a_addr_i;
    assign addr[1]  = b_addr_i;
    assign we[0]    = a_we_i;
    assign we[1]    = b_we_i;
    assign be[0]    = a_be_i;
    assign be[1]    = b_be_i;
    assign wdata[0] = a_wdata_i;
    assign wdata[1] = b_wdata_i;

    assign unused_offset_bits = ^{a_addr_i[OFF-1:0], b_addr_i[OFF-1:0]};

    // Low word-address bits pick the bank, so consecutive words land in different banks.
    for (genvar p = 0; p < 2; p++) begin : g_decode
        assign word[p] = addr[p][ADDR_WIDTH-1:OFF];
        assign oor[p]  = (addr[p] >> ADDR_WIDTH) != 32'd0;
        assign inr[p]  = req[p] & ~oor[p];
        assign bank[p] = BW'(word[p] % WA_W'(NUM_BANKS));
        assign row[p]  = ROW_W'(word[p] / WA_W'(NUM_BANKS));
        assign acc[p]  = gnt[p] & ~oor[p];
    end

    // Out-of-range requests never touch a bank, so they never take part in a conflict.
    assign conflict = inr[0] & inr[1] & (bank[0] == bank[1]);
    assign gnt[0]   = ~rst_i & req[0] & (~conflict | ~prio);
    assign gnt[1]   = ~rst_i & req[1] & (~conflict | prio);
    assign a_gnt_o  = gnt[0];
    assign b_gnt_o  = gnt[1];

    // Priority hands over to the loser only when a conflict was actually arbitrated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio <= 1'b0;
        end else if (conflict) begin
            prio <= ~prio;
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic                  sel_a;
        logic                  sel_b;
        logic                  wen;
        logic [ROW_W-1:0]      brow;
        logic [NBE-1:0]        bbe;
        logic [DATA_WIDTH-1:0] bwd;
        logic [DATA_WIDTH-1:0] mem [DEPTH];

        assign sel_a = acc[0] && (bank[0] == BW'(k));
        assign sel_b = acc[1] && (bank[1] == BW'(k));
        assign wen   = (sel_a & we[0]) | (sel_b & we[1]);
        assign brow  = sel_a ? row[0] : row[1];
        assign bbe   = sel_a ? be[0] : be[1];
        assign bwd   = sel_a ? wdata[0] : wdata[1];

        always_ff @(posedge clk_i) begin
            if (wen) begin
                for (int j = 0; j < NBE; j++) begin
                    if (bbe[j]) begin
                        mem[brow][j*8 +: 8] <= bwd[j*8 +: 8];
                    end
                end
            end
        end

        // Read is taken before the same-edge write lands, giving read-first behaviour.
        assign rd_word[k] = mem[brow];
    end

    logic                  pv [2][RD_LATENCY];
    logic                  pe [2][RD_LATENCY];
    logic [DATA_WIDTH-1:0] pd [2][RD_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < RD_LATENCY; i++) begin
                    pv[p][i] <= 1'b0;
                    pe[p][i] <= 1'b0;
                    pd[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv[p][0] <= gnt[p];
                pe[p][0] <= gnt[p] & oor[p];
                pd[p][0] <= (acc[p] && !we[p]) ? rd_word[bank[p]] : '0;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pv[p][i] <= pv[p][i-1];
                    pe[p][i] <= pe[p][i-1];
                    pd[p][i] <= pd[p][i-1];
                end
            end
        end
    end

    assign a_rvalid_o = pv[0][RD_LATENCY-1];
    assign a_err_o    = pe[0][RD_LATENCY-1];
    assign a_rdata_o  = pd[0][RD_LATENCY-1];
    assign b_rvalid_o = pv[1][RD_LATENCY-1];
    assign b_err_o    = pe[1][RD_LATENCY-1];
    assign b_rdata_o  = pd[1][RD_LATENCY-1];

endmodule

// File: tb/tb_dp_ram_obi_banked.sv
// Scoreboard bench for dp_ram_obi_banked: a word-level memory model predicts grants and responses,
// and an independent monitor matches every response against the expected queue per port.
`timescale 1ns/1ps
module tb_dp_ram_obi_banked;

    localparam int LAT = 3;

    typedef struct {
        bit        req;
        bit [31:0] addr;
        bit        we;
        bit [3:0]  be;
        bit [31:0] wdata;
    } req_t;

    typedef struct {
        int        due;
        bit [31:0] data;
        bit        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a_req, a_gnt, a_we, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_req, b_gnt, b_we, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int   vectors;
    int   miscompares;
    int   cyc;
    int   prio_m;
    req_t cur [2];
    bit [31:0] ref_mem [256];
    exp_t q_a[$];
    exp_t q_b[$];

    dp_ram_obi_banked #(
        .ADDR_WIDTH(15),
        .DATA_WIDTH(32),
        .NUM_BANKS (4),
        .RD_LATENCY(LAT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_req_i   (a_req),
        .a_gnt_o   (a_gnt),
        .a_addr_i  (a_addr),
        .a_we_i    (a_we),
        .a_be_i    (a_be),
        .a_wdata_i (a_wdata),
        .a_rvalid_o(a_rvalid),
        .a_rdata_o (a_rdata),
        .a_err_o   (a_err),
        .b_req_i   (b_req),
        .b_gnt_o   (b_gnt),
        .b_addr_i  (b_addr),
        .b_we_i    (b_we),
        .b_be_i    (b_be),
        .b_wdata_i (b_wdata),
        .b_rvalid_o(b_rvalid),
        .b_rdata_o (b_rdata),
        .b_err_o   (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive the pending requests for one cycle, predict grants from the arbitration rules
    // and enqueue the responses the model expects.
    task automatic applyStimulus();
        bit        g [2];
        bit        oor [2];
        int        bnk [2];
        bit        conflict;
        exp_t      x;
        a_req = cur[0].req; a_addr = cur[0].addr; a_we = cur[0].we; a_be = cur[0].be; a_wdata = cur[0].wdata;
        b_req = cur[1].req; b_addr = cur[1].addr; b_we = cur[1].we; b_be = cur[1].be; b_wdata = cur[1].wdata;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            oor[p] = cur[p].addr >= 32'h0000_8000;
            bnk[p] = int'((cur[p].addr / 4) % 4);
        end
        conflict = cur[0].req && !oor[0] && cur[1].req && !oor[1] && (bnk[0] == bnk[1]);
        if (rst) begin
            g[0] = 1'b0;
            g[1] = 1'b0;
            conflict = 1'b0;
            q_a.delete();
            q_b.delete();
            prio_m = 0;
        end else begin
            for (int p = 0; p < 2; p++) g[p] = cur[p].req && (!conflict || prio_m == p);
        end
        checkOutput("a_gnt", {31'b0, a_gnt}, {31'b0, g[0]});
        checkOutput("b_gnt", {31'b0, b_gnt}, {31'b0, g[1]});
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                x.due  = cyc + LAT;
                x.err  = oor[p];
                x.data = (oor[p] || cur[p].we) ? 32'h0 : ref_mem[cur[p].addr[9:2]];
                if (p == 0) q_a.push_back(x);
                else        q_b.push_back(x);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (g[p] && !oor[p] && cur[p].we) begin
                for (int j = 0; j < 4; j++) begin
                    if (cur[p].be[j]) ref_mem[cur[p].addr[9:2]][j*8 +: 8] = cur[p].wdata[j*8 +: 8];
                end
            end
            if (g[p]) cur[p].req = 1'b0;
        end
        if (conflict) prio_m = 1 - prio_m;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input bit [31:0] addr, input bit we, input bit [3:0] be, input bit [31:0] wd);
        cur[p].req   = 1'b1;
        cur[p].addr  = addr;
        cur[p].we    = we;
        cur[p].be    = be;
        cur[p].wdata = wd;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic monitorPort(input int p);
        bit          v;
        bit          e;
        logic [31:0] d;
        exp_t        x;
        int          qs;
        string       pn;
        pn = (p == 0) ? "a" : "b";
        v  = (p == 0) ? a_rvalid : b_rvalid;
        e  = (p == 0) ? a_err : b_err;
        d  = (p == 0) ? a_rdata : b_rdata;
        qs = (p == 0) ? q_a.size() : q_b.size();
        if (v) begin
            if (qs == 0) begin
                checkOutput({pn, "_unexpected_rvalid"}, 32'd1, 32'd0);
            end else begin
                if (p == 0) x = q_a.pop_front();
                else        x = q_b.pop_front();
                checkOutput({pn, "_rdata"}, d, x.data);
                checkOutput({pn, "_err"}, {31'b0, e}, {31'b0, x.err});
                checkOutput({pn, "_resp_cycle"}, cyc, x.due);
            end
        end else begin
            checkOutput({pn, "_idle_rdata"}, d, 32'h0);
            checkOutput({pn, "_idle_err"}, {31'b0, e}, 32'h0);
            if (qs != 0) begin
                x = (p == 0) ? q_a[0] : q_b[0];
                if (x.due <= cyc) begin
                    checkOutput({pn, "_rvalid_missing"}, 32'd0, 32'd1);
                    if (p == 0) void'(q_a.pop_front());
                    else        void'(q_b.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        monitorPort(0);
        monitorPort(1);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [31:0] ad;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        prio_m      = 0;
        for (int p = 0; p < 2; p++) cur[p] = '{default: '0};
        rst = 1'b1;

        // Grants stay low while reset is held, even with a pending request.
        issue(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0);
        drain(3);
        rst = 1'b0;
        drain(LAT + 2);

        // Fill the modelled window so every later read has a known value.
        for (int w = 0; w < 256; w += 2) begin
            issue(0, w * 4, 1'b1, 4'hF, $urandom);
            issue(1, (w + 1) * 4, 1'b1, 4'hF, $urandom);
            applyStimulus();
        end
        drain(LAT + 1);

        issue(0, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF); applyStimulus();
        issue(0, 32'h100, 1'b0, 4'hF, 32'h0);        applyStimulus();
        drain(LAT + 1);

        issue(1, 32'h200, 1'b1, 4'hF, 32'hFFFFFFFF); applyStimulus();
        issue(1, 32'h200, 1'b1, 4'h5, 32'h11223344); applyStimulus();
        issue(1, 32'h200, 1'b0, 4'hF, 32'h0);        applyStimulus();
        drain(LAT + 1);

        issue(0, 32'h000, 1'b0, 4'hF, 32'h0);
        issue(1, 32'h004, 1'b0, 4'hF, 32'h0);
        applyStimulus();
        drain(LAT + 1);

        issue(0, 32'h008, 1'b0, 4'hF, 32'h0);
        issue(1, 32'h018, 1'b0, 4'hF, 32'h0);
        applyStimulus();
        issue(0, 32'h008, 1'b0, 4'hF, 32'h0);
        applyStimulus();
        applyStimulus();
        drain(LAT + 1);

        issue(0, 32'h0001_0100, 1'b1, 4'hF, 32'h12345678); applyStimulus();
        issue(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0);        applyStimulus();
        issue(0, 32'h100, 1'b0, 4'hF, 32'h0);              applyStimulus();
        drain(LAT + 1);

        // Hand priority to B, then show reset kills an in-flight read and returns priority to A.
        issue(0, 32'h000, 1'b0, 4'hF, 32'h0);
        issue(1, 32'h010, 1'b0, 4'hF, 32'h0);
        applyStimulus();
        applyStimulus();
        drain(LAT + 1);
        issue(0, 32'h100, 1'b0, 4'hF, 32'h0);
        applyStimulus();
        rst = 1'b1;
        drain(2);
        rst = 1'b0;
        drain(LAT + 2);
        issue(0, 32'h020, 1'b0, 4'hF, 32'h0);
        issue(1, 32'h030, 1'b0, 4'hF, 32'h0);
        applyStimulus();
        applyStimulus();
        drain(LAT + 1);

        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!cur[p].req && ($urandom % 4) != 0) begin
                    if (($urandom % 10) == 0) ad = $urandom | 32'h0000_8000;
                    else                      ad = {22'b0, 10'($urandom)};
                    issue(p, ad, 1'($urandom), 4'($urandom), $urandom);
                end
            end
            applyStimulus();
        end
        drain(LAT + 3);

        checkOutput("a_queue_leftover", q_a.size(), 32'd0);
        checkOutput("b_queue_leftover", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
